// File: rtl/id_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module      : id_stage_pipe
// Description : MIPS-I subset decode stage. It contains a 2R/1W register file
//               with writeback bypass and forwarding muxes. Its output is an
//               ID/EX slot that uses a valid/ready handshake and supports flush.
//               Define ID_BRANCH_RESOLVE_EN to resolve branches in this stage.
// Revision    : 1.0 - initial release
// ============================================================================
module id_stage_pipe #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_inst,
    input  logic [DATA_W-1:0]     in_pc,
    input  logic                  flush,
    input  logic                  fwd_a_sel,
    input  logic                  fwd_b_sel,
    input  logic [DATA_W-1:0]     fwd_a_data,
    input  logic [DATA_W-1:0]     fwd_b_data,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [REG_ADDR_W-1:0] out_rs,
    output logic [REG_ADDR_W-1:0] out_rt,
    output logic [REG_ADDR_W-1:0] out_dst,
    output logic [DATA_W-1:0]     out_rs_data,
    output logic [DATA_W-1:0]     out_rt_data,
    output logic [DATA_W-1:0]     out_ext_imm,
    output logic [DATA_W-1:0]     out_pc_plus4,
    output logic [3:0]            out_alu_op,
    output logic                  out_alu_src,
    output logic                  out_reg_write,
    output logic                  out_mem_read,
    output logic                  out_mem_write,
    output logic                  out_mem_to_reg,
    output logic                  out_branch,
    output logic                  out_jump,
    output logic                  out_link,
    output logic                  illegal_inst
`ifdef ID_BRANCH_RESOLVE_EN
    ,
    output logic                  br_taken,
    output logic [DATA_W-1:0]     br_target
`endif
);

    localparam int c_NREG = 1 << REG_ADDR_W;

    localparam logic [3:0] c_ALU_ADD  = 4'd0;
    localparam logic [3:0] c_ALU_SUB  = 4'd1;
    localparam logic [3:0] c_ALU_AND  = 4'd2;
    localparam logic [3:0] c_ALU_OR   = 4'd3;
    localparam logic [3:0] c_ALU_XOR  = 4'd4;
    localparam logic [3:0] c_ALU_NOR  = 4'd5;
    localparam logic [3:0] c_ALU_SLT  = 4'd6;
    localparam logic [3:0] c_ALU_SLTU = 4'd7;
    localparam logic [3:0] c_ALU_SLL  = 4'd8;
    localparam logic [3:0] c_ALU_SRL  = 4'd9;
    localparam logic [3:0] c_ALU_SRA  = 4'd10;
    localparam logic [3:0] c_ALU_LUI  = 4'd11;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_JAL   = 6'h03;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_ADDIU = 6'h09;
    localparam logic [5:0] c_OP_SLTI  = 6'h0A;
    localparam logic [5:0] c_OP_SLTIU = 6'h0B;
    localparam logic [5:0] c_OP_ANDI  = 6'h0C;
    localparam logic [5:0] c_OP_ORI   = 6'h0D;
    localparam logic [5:0] c_OP_XORI  = 6'h0E;
    localparam logic [5:0] c_OP_LUI   = 6'h0F;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    localparam logic [5:0] c_FN_SLL  = 6'h00;
    localparam logic [5:0] c_FN_SRL  = 6'h02;
    localparam logic [5:0] c_FN_SRA  = 6'h03;
    localparam logic [5:0] c_FN_JR   = 6'h08;
    localparam logic [5:0] c_FN_ADD  = 6'h20;
    localparam logic [5:0] c_FN_ADDU = 6'h21;
    localparam logic [5:0] c_FN_SUB  = 6'h22;
    localparam logic [5:0] c_FN_SUBU = 6'h23;
    localparam logic [5:0] c_FN_AND  = 6'h24;
    localparam logic [5:0] c_FN_OR   = 6'h25;
    localparam logic [5:0] c_FN_XOR  = 6'h26;
    localparam logic [5:0] c_FN_NOR  = 6'h27;
    localparam logic [5:0] c_FN_SLT  = 6'h2A;
    localparam logic [5:0] c_FN_SLTU = 6'h2B;

    // ------------------------------------------------------------------
    // Instruction fields and immediate variants
    // ------------------------------------------------------------------
    logic [5:0]            w_op;
    logic [5:0]            w_funct;
    logic [15:0]           w_imm;
    logic [REG_ADDR_W-1:0] w_rs;
    logic [REG_ADDR_W-1:0] w_rt;
    logic [REG_ADDR_W-1:0] w_rd;
    logic [DATA_W-1:0]     w_imm_sext;
    logic [DATA_W-1:0]     w_imm_zext;
    logic [DATA_W-1:0]     w_imm_lui;
    logic [DATA_W-1:0]     w_imm_br;
    logic [DATA_W-1:0]     w_imm_jmp;
    logic [DATA_W-1:0]     w_imm_shamt;
    logic [DATA_W-1:0]     w_pc_plus4;

    assign w_op        = in_inst[31:26];
    assign w_funct     = in_inst[5:0];
    assign w_imm       = in_inst[15:0];
    assign w_rs        = REG_ADDR_W'(in_inst[25:21]);
    assign w_rt        = REG_ADDR_W'(in_inst[20:16]);
    assign w_rd        = REG_ADDR_W'(in_inst[15:11]);
    assign w_imm_sext  = DATA_W'($signed(w_imm));
    assign w_imm_zext  = DATA_W'(w_imm);
    assign w_imm_lui   = DATA_W'({w_imm, 16'h0000});
    assign w_imm_br    = DATA_W'($signed({w_imm, 2'b00}));
    assign w_imm_jmp   = DATA_W'({in_inst[25:0], 2'b00});
    assign w_imm_shamt = DATA_W'(in_inst[10:6]);
    assign w_pc_plus4  = in_pc + DATA_W'(4);

    // ------------------------------------------------------------------
    // Register file: entry 0 is never written and reads as zero
    // ------------------------------------------------------------------
    logic [c_NREG-1:0][DATA_W-1:0] r_rf;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rf <= '0;
        end else if (wb_we && (wb_addr != '0)) begin
            r_rf[wb_addr] <= wb_data;
        end
    end

    logic [DATA_W-1:0] w_rs_arr;
    logic [DATA_W-1:0] w_rt_arr;
    logic [DATA_W-1:0] w_rs_data;
    logic [DATA_W-1:0] w_rt_data;

    assign w_rs_arr = (w_rs == '0) ? '0 : r_rf[w_rs];
    assign w_rt_arr = (w_rt == '0) ? '0 : r_rf[w_rt];

    // Forwarding beats the same-cycle writeback, which beats the array
    always_comb begin
        w_rs_data = w_rs_arr;
        if (fwd_a_sel) begin
            w_rs_data = fwd_a_data;
        end else if (wb_we && (wb_addr == w_rs) && (w_rs != '0)) begin
            w_rs_data = wb_data;
        end
    end

    always_comb begin
        w_rt_data = w_rt_arr;
        if (fwd_b_sel) begin
            w_rt_data = fwd_b_data;
        end else if (wb_we && (wb_addr == w_rt) && (w_rt != '0)) begin
            w_rt_data = wb_data;
        end
    end

    // ------------------------------------------------------------------
    // Decoder
    // ------------------------------------------------------------------
    logic [REG_ADDR_W-1:0] w_dst;
    logic [DATA_W-1:0]     w_ext;
    logic [3:0]            w_alu_op;
    logic                  w_alu_src;
    logic                  w_reg_write;
    logic                  w_mem_read;
    logic                  w_mem_write;
    logic                  w_mem_to_reg;
    logic                  w_branch;
    logic                  w_jump;
    logic                  w_link;
    logic                  w_illegal;

    always_comb begin
        w_dst        = '0;
        w_ext        = '0;
        w_alu_op     = c_ALU_ADD;
        w_alu_src    = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_branch     = 1'b0;
        w_jump       = 1'b0;
        w_link       = 1'b0;
        w_illegal    = 1'b0;

        case (w_op)
            c_OP_RTYPE: begin
                w_dst       = w_rd;
                w_reg_write = 1'b1;
                case (w_funct)
                    c_FN_ADD, c_FN_ADDU: w_alu_op = c_ALU_ADD;
                    c_FN_SUB, c_FN_SUBU: w_alu_op = c_ALU_SUB;
                    c_FN_AND:            w_alu_op = c_ALU_AND;
                    c_FN_OR:             w_alu_op = c_ALU_OR;
                    c_FN_XOR:            w_alu_op = c_ALU_XOR;
                    c_FN_NOR:            w_alu_op = c_ALU_NOR;
                    c_FN_SLT:            w_alu_op = c_ALU_SLT;
                    c_FN_SLTU:           w_alu_op = c_ALU_SLTU;
                    c_FN_SLL, c_FN_SRL, c_FN_SRA: begin
                        w_alu_op  = (w_funct == c_FN_SLL) ? c_ALU_SLL :
                                    (w_funct == c_FN_SRL) ? c_ALU_SRL : c_ALU_SRA;
                        w_alu_src = 1'b1;
                        w_ext     = w_imm_shamt;
                    end
                    c_FN_JR: begin
                        w_jump      = 1'b1;
                        w_reg_write = 1'b0;
                    end
                    default: w_illegal = 1'b1;
                endcase
            end
            c_OP_ADDI, c_OP_ADDIU, c_OP_SLTI, c_OP_SLTIU: begin
                w_dst       = w_rt;
                w_alu_src   = 1'b1;
                w_reg_write = 1'b1;
                w_ext       = w_imm_sext;
                w_alu_op    = (w_op == c_OP_SLTI)  ? c_ALU_SLT  :
                              (w_op == c_OP_SLTIU) ? c_ALU_SLTU : c_ALU_ADD;
            end
            c_OP_ANDI, c_OP_ORI, c_OP_XORI: begin
                w_dst       = w_rt;
                w_alu_src   = 1'b1;
                w_reg_write = 1'b1;
                w_ext       = w_imm_zext;
                w_alu_op    = (w_op == c_OP_ANDI) ? c_ALU_AND :
                              (w_op == c_OP_ORI)  ? c_ALU_OR  : c_ALU_XOR;
            end
            c_OP_LUI: begin
                w_dst       = w_rt;
                w_alu_src   = 1'b1;
                w_reg_write = 1'b1;
                w_ext       = w_imm_lui;
                w_alu_op    = c_ALU_LUI;
            end
            c_OP_LW: begin
                w_dst        = w_rt;
                w_alu_src    = 1'b1;
                w_reg_write  = 1'b1;
                w_mem_read   = 1'b1;
                w_mem_to_reg = 1'b1;
                w_ext        = w_imm_sext;
            end
            c_OP_SW: begin
                w_dst       = w_rt;
                w_alu_src   = 1'b1;
                w_mem_write = 1'b1;
                w_ext       = w_imm_sext;
            end
            c_OP_BEQ, c_OP_BNE: begin
                w_dst    = w_rt;
                w_branch = 1'b1;
                w_alu_op = c_ALU_SUB;
                w_ext    = w_imm_br;
            end
            c_OP_J, c_OP_JAL: begin
                w_jump = 1'b1;
                w_ext  = w_imm_jmp;
                if (w_op == c_OP_JAL) begin
                    w_link      = 1'b1;
                    w_reg_write = 1'b1;
                    w_dst       = '1;
                end
            end
            default: w_illegal = 1'b1;
        endcase

        if (w_illegal) begin
            w_dst        = '0;
            w_ext        = '0;
            w_alu_op     = c_ALU_ADD;
            w_alu_src    = 1'b0;
            w_reg_write  = 1'b0;
            w_mem_read   = 1'b0;
            w_mem_write  = 1'b0;
            w_mem_to_reg = 1'b0;
            w_branch     = 1'b0;
            w_jump       = 1'b0;
            w_link       = 1'b0;
        end

        // Writes to the hardwired zero register are never requested
        if (w_dst == '0) begin
            w_reg_write = 1'b0;
        end
    end

`ifdef ID_BRANCH_RESOLVE_EN
    logic              w_br_taken;
    logic [DATA_W-1:0] w_br_target;

    assign w_br_taken  = w_branch && ((w_op == c_OP_BEQ) == (w_rs_data == w_rt_data));
    assign w_br_target = w_branch ? (w_pc_plus4 + w_ext) : '0;
`endif

    // ------------------------------------------------------------------
    // ID/EX slot
    // ------------------------------------------------------------------
    logic                  r_valid;
    logic [REG_ADDR_W-1:0] r_rs;
    logic [REG_ADDR_W-1:0] r_rt;
    logic [REG_ADDR_W-1:0] r_dst;
    logic [DATA_W-1:0]     r_rs_data;
    logic [DATA_W-1:0]     r_rt_data;
    logic [DATA_W-1:0]     r_ext;
    logic [DATA_W-1:0]     r_pc_plus4;
    logic [3:0]            r_alu_op;
    logic [7:0]            r_ctrl;
    logic                  r_illegal;
`ifdef ID_BRANCH_RESOLVE_EN
    logic                  r_br_taken;
    logic [DATA_W-1:0]     r_br_target;
`endif

    logic w_in_ready;
    logic w_capture;

    assign w_in_ready = !r_valid || out_ready;
    assign w_capture  = in_valid && w_in_ready && !flush;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid     <= 1'b0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_dst       <= '0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_ext       <= '0;
            r_pc_plus4  <= '0;
            r_alu_op    <= '0;
            r_ctrl      <= '0;
            r_illegal   <= 1'b0;
`ifdef ID_BRANCH_RESOLVE_EN
            r_br_taken  <= 1'b0;
            r_br_target <= '0;
`endif
        end else if (w_capture) begin
            r_valid     <= 1'b1;
            r_rs        <= w_rs;
            r_rt        <= w_rt;
            r_dst       <= w_dst;
            r_rs_data   <= w_rs_data;
            r_rt_data   <= w_rt_data;
            r_ext       <= w_ext;
            r_pc_plus4  <= w_pc_plus4;
            r_alu_op    <= w_alu_op;
            r_ctrl      <= {w_alu_src, w_reg_write, w_mem_read, w_mem_write,
                            w_mem_to_reg, w_branch, w_jump, w_link};
            r_illegal   <= w_illegal;
`ifdef ID_BRANCH_RESOLVE_EN
            r_br_taken  <= w_br_taken;
            r_br_target <= w_br_target;
`endif
        end else if (flush || out_ready) begin
            // Slot empties; payload holds, status flags drop with valid
            r_valid     <= 1'b0;
            r_illegal   <= 1'b0;
`ifdef ID_BRANCH_RESOLVE_EN
            r_br_taken  <= 1'b0;
            r_br_target <= '0;
`endif
        end
    end

    assign in_ready       = w_in_ready;
    assign out_valid      = r_valid;
    assign out_rs         = r_rs;
    assign out_rt         = r_rt;
    assign out_dst        = r_dst;
    assign out_rs_data    = r_rs_data;
    assign out_rt_data    = r_rt_data;
    assign out_ext_imm    = r_ext;
    assign out_pc_plus4   = r_pc_plus4;
    assign out_alu_op     = r_alu_op;
    assign out_alu_src    = r_ctrl[7];
    assign out_reg_write  = r_ctrl[6];
    assign out_mem_read   = r_ctrl[5];
    assign out_mem_write  = r_ctrl[4];
    assign out_mem_to_reg = r_ctrl[3];
    assign out_branch     = r_ctrl[2];
    assign out_jump       = r_ctrl[1];
    assign out_link       = r_ctrl[0];
    assign illegal_inst   = r_illegal;
`ifdef ID_BRANCH_RESOLVE_EN
    assign br_taken       = r_br_taken;
    assign br_target      = r_br_target;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_stage_pipe
// Description : Scoreboard bench for id_stage_pipe with a reference decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid, in_ready, flush;
    logic [31:0] in_inst, in_pc;
    logic        fwd_a_sel, fwd_b_sel;
    logic [31:0] fwd_a_data, fwd_b_data;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid, out_ready;
    logic [4:0]  out_rs, out_rt, out_dst;
    logic [31:0] out_rs_data, out_rt_data, out_ext_imm, out_pc_plus4;
    logic [3:0]  out_alu_op;
    logic        out_alu_src, out_reg_write, out_mem_read, out_mem_write;
    logic        out_mem_to_reg, out_branch, out_jump, out_link, illegal_inst;
`ifdef ID_BRANCH_RESOLVE_EN
    logic        br_taken;
    logic [31:0] br_target;
`endif

    always #5 clk = ~clk;

    id_stage_pipe #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .flush(flush),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .fwd_a_data(fwd_a_data), .fwd_b_data(fwd_b_data),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs(out_rs), .out_rt(out_rt), .out_dst(out_dst),
        .out_rs_data(out_rs_data), .out_rt_data(out_rt_data),
        .out_ext_imm(out_ext_imm), .out_pc_plus4(out_pc_plus4),
        .out_alu_op(out_alu_op), .out_alu_src(out_alu_src),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_mem_to_reg(out_mem_to_reg),
        .out_branch(out_branch), .out_jump(out_jump), .out_link(out_link),
        .illegal_inst(illegal_inst)
`ifdef ID_BRANCH_RESOLVE_EN
        , .br_taken(br_taken), .br_target(br_target)
`endif
    );

    typedef struct {
        logic [4:0]  rs, rt, dst;
        logic [31:0] a, b, ext, pc4, btgt;
        logic [3:0]  alu;
        logic        alu_src, rw, mr, mw, m2r, br, j, lnk, ill, btk;
        bit          chk_dst, chk_ext, chk_alu;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    logic [31:0] mreg [32];
    bit          m_valid;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference decoder written from the ISA tables
    function automatic exp_t ref_decode(input logic [31:0] inst, input logic [31:0] pc,
                                        input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [31:0] sext;
        op   = inst[31:26];
        fn   = inst[5:0];
        imm  = inst[15:0];
        sext = 32'($signed(imm));
        e = '{default: '0};
        e.rs = inst[25:21]; e.rt = inst[20:16];
        e.a = a; e.b = b; e.pc4 = pc + 32'd4;
        e.chk_dst = 1; e.chk_ext = 1; e.chk_alu = 1;
        case (op)
            6'h00: begin
                e.dst = inst[15:11]; e.rw = 1; e.chk_ext = 0;
                case (fn)
                    6'h20, 6'h21: e.alu = 0;
                    6'h22, 6'h23: e.alu = 1;
                    6'h24: e.alu = 2;
                    6'h25: e.alu = 3;
                    6'h26: e.alu = 4;
                    6'h27: e.alu = 5;
                    6'h2A: e.alu = 6;
                    6'h2B: e.alu = 7;
                    6'h00, 6'h02, 6'h03: begin
                        e.alu = (fn == 6'h00) ? 4'd8 : (fn == 6'h02) ? 4'd9 : 4'd10;
                        e.alu_src = 1; e.ext = 32'(inst[10:6]); e.chk_ext = 1;
                    end
                    6'h08: begin
                        e.j = 1; e.rw = 0; e.chk_dst = 0; e.chk_alu = 0;
                    end
                    default: e.ill = 1;
                endcase
            end
            6'h08, 6'h09, 6'h0A, 6'h0B: begin
                e.dst = e.rt; e.rw = 1; e.alu_src = 1; e.ext = sext;
                e.alu = (op == 6'h0A) ? 4'd6 : (op == 6'h0B) ? 4'd7 : 4'd0;
            end
            6'h0C, 6'h0D, 6'h0E: begin
                e.dst = e.rt; e.rw = 1; e.alu_src = 1; e.ext = 32'(imm);
                e.alu = (op == 6'h0C) ? 4'd2 : (op == 6'h0D) ? 4'd3 : 4'd4;
            end
            6'h0F: begin
                e.dst = e.rt; e.rw = 1; e.alu_src = 1; e.alu = 11;
                e.ext = 32'(imm) * 32'd65536;
            end
            6'h23: begin
                e.dst = e.rt; e.rw = 1; e.alu_src = 1; e.mr = 1; e.m2r = 1; e.ext = sext;
            end
            6'h2B: begin
                e.dst = e.rt; e.alu_src = 1; e.mw = 1; e.ext = sext;
            end
            6'h04, 6'h05: begin
                e.dst = e.rt; e.br = 1; e.alu = 1; e.ext = sext * 32'd4;
                e.btk  = (op == 6'h04) ? (a == b) : (a != b);
                e.btgt = pc + 32'd4 + e.ext;
            end
            6'h02, 6'h03: begin
                e.j = 1; e.ext = 32'(inst[25:0]) * 32'd4; e.chk_alu = 0;
                if (op == 6'h03) begin
                    e.lnk = 1; e.rw = 1; e.dst = 5'd31;
                end else begin
                    e.chk_dst = 0;
                end
            end
            default: e.ill = 1;
        endcase
        if (e.ill) begin
            e.rw = 0; e.alu_src = 0; e.chk_dst = 0; e.chk_ext = 0; e.chk_alu = 0;
        end
        if (e.dst == 5'd0) e.rw = 0;
        return e;
    endfunction

    function automatic logic [31:0] operand(input logic [4:0] addr, input logic sel,
                                            input logic [31:0] fdat);
        if (sel) return fdat;
        if (addr == 5'd0) return 32'd0;
        if (wb_we && wb_addr == addr) return wb_data;
        return mreg[addr];
    endfunction

    // One clock of stimulus: predict, take the edge, commit the model
    task automatic cycle();
        bit   cap;
        exp_t e;
        cap = in_valid && (!m_valid || out_ready) && !flush;
        e = ref_decode(in_inst, in_pc, operand(in_inst[25:21], fwd_a_sel, fwd_a_data),
                       operand(in_inst[20:16], fwd_b_sel, fwd_b_data));
        @(posedge clk);
        if (flush) begin
            if (m_valid && !out_ready && q.size() > 0) void'(q.pop_front());
            m_valid = 0;
        end else if (cap) begin
            q.push_back(e);
            m_valid = 1;
        end else if (out_ready) begin
            m_valid = 0;
        end
        if (wb_we && wb_addr != 5'd0) mreg[wb_addr] = wb_data;
        #1;
    endtask

    task automatic set_in(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                          input logic fl, input logic ord);
        in_valid = v; in_inst = inst; in_pc = pc; flush = fl; out_ready = ord;
    endtask

    task automatic set_wb(input logic we, input logic [4:0] a, input logic [31:0] d);
        wb_we = we; wb_addr = a; wb_data = d;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [5:0] fns  [14] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                                  6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h08};
        logic [5:0] iops [12] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
                                  6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05};
        int         k;
        logic [4:0] rs, rt, rd;
        logic [5:0] fn;
        k  = $urandom_range(0, 19);
        rs = 5'($urandom_range(0, 7));
        rt = 5'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 7));
        if (k < 5) begin
            fn = (k == 4) ? 6'(6'h30 + $urandom_range(0, 15)) : fns[$urandom_range(0, 13)];
            return {6'h00, rs, rt, rd, 5'($urandom_range(0, 31)), fn};
        end else if (k < 17) begin
            return {iops[$urandom_range(0, 11)], rs, rt, 16'($urandom())};
        end else if (k == 17) begin
            return {6'h02, 26'($urandom())};
        end else if (k == 18) begin
            return {6'h03, 26'($urandom())};
        end
        return {6'(6'h30 + $urandom_range(0, 15)), 26'($urandom())};
    endfunction

    // Monitor: compare the slot to the scoreboard head while it is valid
    always @(negedge clk) begin
        if (rstn) begin
            chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL scoreboard: actual=slot_valid required=no_pending_entry");
                end else begin
                    mon_e = q[0];
                    chk("rs", 32'(out_rs), 32'(mon_e.rs));
                    chk("rt", 32'(out_rt), 32'(mon_e.rt));
                    chk("rs_data", out_rs_data, mon_e.a);
                    chk("rt_data", out_rt_data, mon_e.b);
                    chk("pc_plus4", out_pc_plus4, mon_e.pc4);
                    if (mon_e.chk_dst) chk("dst", 32'(out_dst), 32'(mon_e.dst));
                    if (mon_e.chk_ext) chk("ext_imm", out_ext_imm, mon_e.ext);
                    if (mon_e.chk_alu) chk("alu_op", 32'(out_alu_op), 32'(mon_e.alu));
                    chk("ctrl", 32'({out_alu_src, out_reg_write, out_mem_read, out_mem_write,
                                     out_mem_to_reg, out_branch, out_jump, out_link}),
                        32'({mon_e.alu_src, mon_e.rw, mon_e.mr, mon_e.mw,
                             mon_e.m2r, mon_e.br, mon_e.j, mon_e.lnk}));
                    chk("illegal", 32'(illegal_inst), 32'(mon_e.ill));
`ifdef ID_BRANCH_RESOLVE_EN
                    chk("br_taken", 32'(br_taken), 32'(mon_e.btk));
                    chk("br_target", br_target, mon_e.btgt);
`endif
                    if (out_ready) void'(q.pop_front());
                end
            end
`ifdef ID_BRANCH_RESOLVE_EN
            else begin
                chk("br_idle", 32'({br_taken, br_target}), 32'd0);
            end
`endif
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_illegal"}, 32'(illegal_inst), 32'd0);
        chk({tag, "_regs"}, 32'({out_rs, out_rt, out_dst}), 32'd0);
        chk({tag, "_data"}, out_rs_data | out_rt_data | out_ext_imm | out_pc_plus4, 32'd0);
        chk({tag, "_ctrl"}, 32'({out_alu_op, out_alu_src, out_reg_write, out_mem_read,
                                 out_mem_write, out_mem_to_reg, out_branch, out_jump,
                                 out_link}), 32'd0);
`ifdef ID_BRANCH_RESOLVE_EN
        chk({tag, "_br"}, 32'(br_taken) | br_target, 32'd0);
`endif
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
        m_valid = 0;
        rstn = 1'b0;
        set_in(0, 32'd0, 32'd0, 0, 0);
        set_wb(0, 5'd0, 32'd0);
        fwd_a_sel = 0; fwd_b_sel = 0; fwd_a_data = 32'd0; fwd_b_data = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rstn = 1'b1;
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        // Write r5 then decode ADDI r6,r5,-1
        set_wb(1, 5'd5, 32'h1234);
        set_in(0, 32'd0, 32'd0, 0, 1);
        cycle();
        set_wb(0, 5'd0, 32'd0);
        set_in(1, 32'h20A6FFFF, 32'h40, 0, 1);
        cycle();
        chk("addi_rs_data", out_rs_data, 32'h1234);
        chk("addi_ext", out_ext_imm, 32'hFFFFFFFF);
        chk("addi_dst", 32'(out_dst), 32'd6);
        chk("addi_alu", 32'({out_alu_op, out_alu_src}), 32'h01);

        // Same-cycle writeback bypass: OR r7,r5,r0
        set_wb(1, 5'd5, 32'hAA);
        set_in(1, 32'h00A03825, 32'h44, 0, 1);
        cycle();
        set_wb(0, 5'd0, 32'd0);
        chk("bypass_rs_data", out_rs_data, 32'hAA);
        chk("bypass_rt_data", out_rt_data, 32'd0);
        chk("bypass_alu", 32'(out_alu_op), 32'd3);

        // r0 stays zero after a write attempt
        set_wb(1, 5'd0, 32'h55);
        set_in(0, 32'd0, 32'd0, 0, 1);
        cycle();
        set_wb(0, 5'd0, 32'd0);
        set_in(1, 32'h00004025, 32'h48, 0, 1);
        cycle();
        chk("r0_rs_data", out_rs_data, 32'd0);

        // Stall for three cycles with a new instruction waiting
        set_in(1, 32'h21290001, 32'h4C, 0, 1);
        cycle();
        set_in(1, 32'h00A03825, 32'h50, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_dst", 32'(out_dst), 32'd9);
        end
        out_ready = 1;
        cycle();
        chk("after_stall_dst", 32'(out_dst), 32'd7);
        chk("after_stall_pc4", out_pc_plus4, 32'h54);

        // Flush drops held and incoming instruction
        set_in(1, 32'h21290001, 32'h58, 1, 0);
        cycle();
        chk("flush_valid", 32'(out_valid), 32'd0);

        // Illegal opcode
        set_in(1, 32'hFC000000, 32'h5C, 0, 1);
        cycle();
        chk("illegal_flag", 32'({out_valid, illegal_inst}), 32'h3);
        chk("illegal_ctrl", 32'({out_alu_src, out_reg_write, out_mem_read, out_mem_write,
                                 out_mem_to_reg, out_branch, out_jump, out_link}), 32'd0);

`ifdef ID_BRANCH_RESOLVE_EN
        fwd_a_sel = 1; fwd_b_sel = 1; fwd_a_data = 32'd7; fwd_b_data = 32'd7;
        set_in(1, 32'h10220004, 32'h100, 0, 1);
        cycle();
        chk("beq_taken", 32'(br_taken), 32'd1);
        chk("beq_target", br_target, 32'h114);
        set_in(1, 32'h14220004, 32'h100, 0, 1);
        cycle();
        chk("bne_taken", 32'(br_taken), 32'd0);
        fwd_a_sel = 0; fwd_b_sel = 0;
`endif

        // Asynchronous reset in the middle of a stall
        set_in(1, 32'h21290001, 32'h60, 0, 1);
        cycle();
        out_ready = 0;
        cycle();
        cycle();
        rstn = 1'b0;
        #1;
        chk_all_zero("async_reset");
        m_valid = 0;
        q.delete();
        for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
        set_in(0, 32'd0, 32'd0, 0, 1);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        #1;
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            set_in(($urandom_range(0, 3) != 0), rand_inst(), ($urandom() & 32'hFFFF_FFFC),
                   ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));
            set_wb($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom());
            fwd_a_sel  = ($urandom_range(0, 7) == 0);
            fwd_b_sel  = ($urandom_range(0, 7) == 0);
            fwd_a_data = $urandom();
            fwd_b_data = (fwd_a_sel && $urandom_range(0, 1) == 1) ? fwd_a_data : $urandom();
            cycle();
        end

        set_in(0, 32'd0, 32'd0, 0, 1);
        set_wb(0, 5'd0, 32'd0);
        fwd_a_sel = 0; fwd_b_sel = 0;
        repeat (3) cycle();
        chk("drain_queue", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
